// File: rtl/ieeedrv_sd_arb_if.sv
// rtl/ieeedrv_sd_arb_if.sv - shared MiSTer SD block port between arbiter and host
interface ieeedrv_sd_arb_if;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_wr
  );
endinterface

// File: rtl/ieeedrv_sd_arb.sv
// rtl/ieeedrv_sd_arb.sv - round-robin arbiter sharing one SD block port among sub-drives
module ieeedrv_sd_arb #(
  parameter int          SUBDRV  = 2,
  parameter logic [23:0] TIMEOUT = 24'd0,
  localparam int         GW      = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic [SUBDRV-1:0]     req_rd,
  input  logic [SUBDRV-1:0]     req_wr,
  input  logic [32*SUBDRV-1:0]  req_lba,
  input  logic [6*SUBDRV-1:0]   req_blk_cnt,
  input  logic [8*SUBDRV-1:0]   drv_buff_din,
  output logic [SUBDRV-1:0]     drv_ack,
  output logic [SUBDRV-1:0]     drv_buff_wr,
  output logic [SUBDRV-1:0]     drv_err,
  output logic                  busy,
  output logic [GW-1:0]         grant,
  ieeedrv_sd_arb_if.master      sd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  state_t      state;
  logic [GW-1:0] ptr;
  logic [23:0] tmo_cnt;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  int            pos;
  int            sel;

  // First pending drive at or after ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pos        = 0;
    for (int k = 0; k < SUBDRV; k++) begin
      pos = (int'(ptr) + k) % SUBDRV;
      if (!pick_found && (req_rd[pos] || req_wr[pos])) begin
        pick_found = 1'b1;
        pick_idx   = GW'(pos);
      end
    end
  end

  assign sel = int'(pick_idx);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      sd.sd_rd      <= 1'b0;
      sd.sd_wr      <= 1'b0;
      sd.sd_lba     <= '0;
      sd.sd_blk_cnt <= '0;
      grant         <= '0;
      ptr           <= '0;
      drv_err       <= '0;
      tmo_cnt       <= '0;
    end else begin
      drv_err <= '0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant         <= pick_idx;
            sd.sd_lba     <= req_lba[sel*32 +: 32];
            sd.sd_blk_cnt <= req_blk_cnt[sel*6 +: 6];
            // Write wins when both are raised; the read stays pending.
            sd.sd_wr      <= req_wr[sel];
            sd.sd_rd      <= ~req_wr[sel];
            tmo_cnt       <= '0;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (sd.sd_ack) begin
            sd.sd_rd <= 1'b0;
            sd.sd_wr <= 1'b0;
            state    <= S_XFER;
          end else if ((TIMEOUT != 24'd0) && (tmo_cnt == TIMEOUT - 24'd1)) begin
            sd.sd_rd       <= 1'b0;
            sd.sd_wr       <= 1'b0;
            drv_err[grant] <= 1'b1;
            state          <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        S_XFER: begin
          if (!sd.sd_ack) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Gap cycle lets the served requester drop its level request.
          ptr   <= (grant == GW'(SUBDRV - 1)) ? '0 : grant + GW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    drv_ack = '0;
    if ((state == S_REQ) || (state == S_XFER)) begin
      drv_ack[grant] = sd.sd_ack;
    end
  end

  assign drv_buff_wr    = drv_ack & {SUBDRV{sd.sd_buff_wr}};
  assign sd.sd_buff_din = drv_buff_din[int'(grant)*8 +: 8];
  assign busy           = (state != S_IDLE);

endmodule
